// File: rtl/data_buffer_arbiter.sv
// Endpoint data buffer arbiter: owns the circular pointers and occupancy of the
// single-port buffer RAM and shares it between the USB byte paths and the AHB slave.
module data_buffer_arbiter #(
   parameter int DEPTH        = 64,
   parameter int ADDR_W       = 6,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              usb_store_req,
   input  logic [7:0]        usb_store_data,
   input  logic              usb_get_req,
   input  logic              ahb_store_req,
   input  logic [7:0]        ahb_store_data,
   input  logic              ahb_get_req,
   output logic              usb_ack,
   output logic              ahb_ack,
   output logic              usb_rvalid,
   output logic              ahb_rvalid,
   output logic [7:0]        usb_rdata,
   output logic [7:0]        ahb_rdata,
   output logic              store_overflow,
   output logic              get_underflow,
   output logic [ADDR_W:0]   buffer_occupancy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic              mem_ren,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [ADDR_W:0] FULL_OCC   = (ADDR_W + 1)'(DEPTH);
   localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

   state_t state_q, state_d;

   logic              op_ahb_q, op_ahb_d;
   logic              op_store_q, op_store_d;
   logic [7:0]        op_data_q, op_data_d;
   logic              op_empty_q, op_empty_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   occ_q, occ_d;

   logic              usb_ack_q, usb_ack_d;
   logic              ahb_ack_q, ahb_ack_d;
   logic              usb_rvalid_q, usb_rvalid_d;
   logic              ahb_rvalid_q, ahb_rvalid_d;
   logic [7:0]        usb_rdata_q, usb_rdata_d;
   logic [7:0]        ahb_rdata_q, ahb_rdata_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_wen_q, mem_wen_d;
   logic              mem_ren_q, mem_ren_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;

   logic any_usb;
   logic any_ahb;

   assign any_usb = usb_store_req | usb_get_req;
   assign any_ahb = ahb_store_req | ahb_get_req;

   always_comb begin
      state_d      = state_q;
      op_ahb_d     = op_ahb_q;
      op_store_d   = op_store_q;
      op_data_d    = op_data_q;
      op_empty_d   = op_empty_q;
      starve_d     = any_ahb ? starve_q : '0;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      occ_d        = occ_q;
      usb_ack_d    = 1'b0;
      ahb_ack_d    = 1'b0;
      usb_rvalid_d = 1'b0;
      ahb_rvalid_d = 1'b0;
      usb_rdata_d  = 8'h00;
      ahb_rdata_d  = 8'h00;
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;
      mem_addr_d   = '0;
      mem_wen_d    = 1'b0;
      mem_ren_d    = 1'b0;
      mem_wdata_d  = 8'h00;

      case (state_q)
         IDLE: begin
            if (any_usb || any_ahb) begin
               // AHB only wins when USB is idle or has hogged the buffer long enough
               if (any_ahb && (!any_usb || starve_q == STARVE_MAX)) begin
                  op_ahb_d   = 1'b1;
                  op_store_d = ahb_store_req;
                  op_data_d  = ahb_store_data;
                  starve_d   = '0;
               end else begin
                  op_ahb_d   = 1'b0;
                  op_store_d = usb_store_req;
                  op_data_d  = usb_store_data;
                  if (any_ahb && starve_q != STARVE_MAX) begin
                     starve_d = starve_q + 1'b1;
                  end
               end
               state_d = ACCESS;
            end
         end

         ACCESS: begin
            if (op_ahb_q) ahb_ack_d = 1'b1;
            else          usb_ack_d = 1'b1;
            if (op_store_q) begin
               if (occ_q == FULL_OCC) begin
                  overflow_d = 1'b1;
               end else begin
                  mem_wen_d   = 1'b1;
                  mem_addr_d  = wr_ptr_q;
                  mem_wdata_d = op_data_q;
                  wr_ptr_d    = wr_ptr_q + 1'b1;
                  occ_d       = occ_q + 1'b1;
               end
               state_d = IDLE;
            end else begin
               if (occ_q == '0) begin
                  underflow_d = 1'b1;
                  op_empty_d  = 1'b1;
               end else begin
                  mem_ren_d  = 1'b1;
                  mem_addr_d = rd_ptr_q;
                  rd_ptr_d   = rd_ptr_q + 1'b1;
                  occ_d      = occ_q - 1'b1;
                  op_empty_d = 1'b0;
               end
               state_d = RDATA;
            end
         end

         RDATA: begin
            if (op_ahb_q) begin
               ahb_rvalid_d = 1'b1;
               ahb_rdata_d  = op_empty_q ? 8'h00 : mem_rdata;
            end else begin
               usb_rvalid_d = 1'b1;
               usb_rdata_d  = op_empty_q ? 8'h00 : mem_rdata;
            end
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase

      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         op_ahb_q     <= 1'b0;
         op_store_q   <= 1'b0;
         op_data_q    <= 8'h00;
         op_empty_q   <= 1'b0;
         starve_q     <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         occ_q        <= '0;
         usb_ack_q    <= 1'b0;
         ahb_ack_q    <= 1'b0;
         usb_rvalid_q <= 1'b0;
         ahb_rvalid_q <= 1'b0;
         usb_rdata_q  <= 8'h00;
         ahb_rdata_q  <= 8'h00;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wen_q    <= 1'b0;
         mem_ren_q    <= 1'b0;
         mem_wdata_q  <= 8'h00;
      end else begin
         state_q      <= state_d;
         op_ahb_q     <= op_ahb_d;
         op_store_q   <= op_store_d;
         op_data_q    <= op_data_d;
         op_empty_q   <= op_empty_d;
         starve_q     <= starve_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
         usb_ack_q    <= usb_ack_d;
         ahb_ack_q    <= ahb_ack_d;
         usb_rvalid_q <= usb_rvalid_d;
         ahb_rvalid_q <= ahb_rvalid_d;
         usb_rdata_q  <= usb_rdata_d;
         ahb_rdata_q  <= ahb_rdata_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
         mem_addr_q   <= mem_addr_d;
         mem_wen_q    <= mem_wen_d;
         mem_ren_q    <= mem_ren_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign usb_ack          = usb_ack_q;
   assign ahb_ack          = ahb_ack_q;
   assign usb_rvalid       = usb_rvalid_q;
   assign ahb_rvalid       = ahb_rvalid_q;
   assign usb_rdata        = usb_rdata_q;
   assign ahb_rdata        = ahb_rdata_q;
   assign store_overflow   = overflow_q;
   assign get_underflow    = underflow_q;
   assign buffer_occupancy = occ_q;
   assign mem_addr         = mem_addr_q;
   assign mem_wen          = mem_wen_q;
   assign mem_ren          = mem_ren_q;
   assign mem_wdata        = mem_wdata_q;

endmodule

// File: tb/tb_data_buffer_arbiter.sv
// Bench for data_buffer_arbiter: table-driven single transactions with a read-data
// scoreboard, plus hand-written reset, overflow/wrap, clear and starvation sequences.
module tb_data_buffer_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear;
   logic       usb_store_req;
   logic [7:0] usb_store_data;
   logic       usb_get_req;
   logic       ahb_store_req;
   logic [7:0] ahb_store_data;
   logic       ahb_get_req;
   logic       usb_ack, ahb_ack, usb_rvalid, ahb_rvalid;
   logic [7:0] usb_rdata, ahb_rdata;
   logic       store_overflow, get_underflow;
   logic [6:0] buffer_occupancy;
   logic [5:0] mem_addr;
   logic       mem_wen, mem_ren;
   logic [7:0] mem_wdata, mem_rdata;

   logic [7:0] ram [64];

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic       side;
      logic       store;
      logic [7:0] data;
      logic [5:0] exp_addr;
      logic       exp_flag;
      logic [6:0] exp_occ;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t       tbl [8];
   logic [7:0] exp_q [$];

   data_buffer_arbiter #(.DEPTH(64), .ADDR_W(6), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .usb_store_req(usb_store_req), .usb_store_data(usb_store_data),
      .usb_get_req(usb_get_req),
      .ahb_store_req(ahb_store_req), .ahb_store_data(ahb_store_data),
      .ahb_get_req(ahb_get_req),
      .usb_ack(usb_ack), .ahb_ack(ahb_ack),
      .usb_rvalid(usb_rvalid), .ahb_rvalid(ahb_rvalid),
      .usb_rdata(usb_rdata), .ahb_rdata(ahb_rdata),
      .store_overflow(store_overflow), .get_underflow(get_underflow),
      .buffer_occupancy(buffer_occupancy),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Buffer RAM: write on the strobe, read data follows the registered address
   always @(posedge clk) begin
      if (mem_wen) ram[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = ram[mem_addr];

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic dropReqs();
      usb_store_req = 1'b0;
      usb_get_req   = 1'b0;
      ahb_store_req = 1'b0;
      ahb_get_req   = 1'b0;
   endtask

   task automatic resetDut();
      rst   = 1'b1;
      clear = 1'b0;
      dropReqs();
      usb_store_data = 8'h00;
      ahb_store_data = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [63:0] allOutputs();
      return {19'd0, usb_ack, ahb_ack, usb_rvalid, ahb_rvalid, usb_rdata, ahb_rdata,
              store_overflow, get_underflow, buffer_occupancy, mem_addr, mem_wen,
              mem_ren, mem_wdata};
   endfunction

   // One complete handshake from an idle arbiter, checked against the record
   task automatic applyStimulus(input vec_t v);
      int   wait_cnt;
      logic got_ack;
      @(negedge clk);
      if (v.side) begin
         ahb_store_req  = v.store;
         ahb_get_req    = !v.store;
         ahb_store_data = v.data;
      end else begin
         usb_store_req  = v.store;
         usb_get_req    = !v.store;
         usb_store_data = v.data;
      end
      wait_cnt = 0;
      got_ack  = 1'b0;
      while (!got_ack && wait_cnt < 10) begin
         @(negedge clk);
         wait_cnt++;
         if (usb_ack || ahb_ack) got_ack = 1'b1;
      end
      dropReqs();
      checkOutput("ack_seen", got_ack, 1);
      if (got_ack) begin
         checkOutput("ack_latency", wait_cnt, 2);
         checkOutput("ack_side", {ahb_ack, usb_ack}, v.side ? 2'b10 : 2'b01);
         if (v.store) begin
            checkOutput("mem_wen", mem_wen, !v.exp_flag);
            checkOutput("store_overflow", store_overflow, v.exp_flag);
            if (!v.exp_flag) begin
               checkOutput("store_addr", mem_addr, v.exp_addr);
               checkOutput("store_wdata", mem_wdata, v.data);
            end
         end else begin
            checkOutput("mem_ren", mem_ren, !v.exp_flag);
            checkOutput("get_underflow", get_underflow, v.exp_flag);
            if (!v.exp_flag) checkOutput("get_addr", mem_addr, v.exp_addr);
            exp_q.push_back(v.exp_rdata);
         end
         checkOutput("occupancy", buffer_occupancy, v.exp_occ);
         if (!v.store) begin
            @(negedge clk);
            checkOutput("rvalid_side", {ahb_rvalid, usb_rvalid}, v.side ? 2'b10 : 2'b01);
            if (exp_q.size() > 0) begin
               checkOutput("rdata", v.side ? ahb_rdata : usb_rdata, exp_q.pop_front());
            end
         end
      end
   endtask

   initial begin
      vec_t v;
      logic grants [10];
      logic exp_grants [10];
      int   n_grants;
      int   cyc;

      tbl[0] = '{1'b0, 1'b1, 8'hA1, 6'd0, 1'b0, 7'd1, 8'h00};
      tbl[1] = '{1'b0, 1'b1, 8'hB2, 6'd1, 1'b0, 7'd2, 8'h00};
      tbl[2] = '{1'b0, 1'b1, 8'hC3, 6'd2, 1'b0, 7'd3, 8'h00};
      tbl[3] = '{1'b1, 1'b0, 8'h00, 6'd0, 1'b0, 7'd2, 8'hA1};
      tbl[4] = '{1'b1, 1'b0, 8'h00, 6'd1, 1'b0, 7'd1, 8'hB2};
      tbl[5] = '{1'b1, 1'b0, 8'h00, 6'd2, 1'b0, 7'd0, 8'hC3};
      tbl[6] = '{1'b1, 1'b0, 8'h00, 6'd0, 1'b1, 7'd0, 8'h00};
      tbl[7] = '{1'b1, 1'b1, 8'h5A, 6'd3, 1'b0, 7'd1, 8'h00};
      exp_grants = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 64; i++) ram[i] = 8'h00;

      $display("[TB] reset state");
      resetDut();
      @(negedge clk);
      checkOutput("reset_outputs", allOutputs(), 0);

      $display("[TB] reset in the middle of an access");
      applyStimulus('{1'b0, 1'b1, 8'h11, 6'd0, 1'b0, 7'd1, 8'h00});
      @(negedge clk);
      usb_store_req  = 1'b1;
      usb_store_data = 8'h77;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midreset_outputs", allOutputs(), 0);
      usb_store_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("post_reset_quiet", {usb_ack, ahb_ack, usb_rvalid, ahb_rvalid, mem_wen}, 0);
      end
      checkOutput("post_reset_occ", buffer_occupancy, 0);

      $display("[TB] vector table");
      for (int i = 0; i < 8; i++) applyStimulus(tbl[i]);
      applyStimulus('{1'b0, 1'b0, 8'h00, 6'd3, 1'b0, 7'd0, 8'h5A});

      $display("[TB] fill, overflow and pointer wrap");
      resetDut();
      for (int i = 0; i < 64; i++) begin
         v = '{i[0], 1'b1, 8'(i) ^ 8'h3C, 6'(i), 1'b0, 7'(i + 1), 8'h00};
         applyStimulus(v);
      end
      applyStimulus('{1'b0, 1'b1, 8'hEE, 6'd0, 1'b1, 7'd64, 8'h00});
      applyStimulus('{1'b1, 1'b0, 8'h00, 6'd0, 1'b0, 7'd63, 8'h3C});
      applyStimulus('{1'b0, 1'b1, 8'h99, 6'd0, 1'b0, 7'd64, 8'h00});

      $display("[TB] clear during a store access");
      resetDut();
      for (int i = 0; i < 5; i++) applyStimulus('{1'b0, 1'b1, 8'(i + 16), 6'(i), 1'b0, 7'(i + 1), 8'h00});
      @(negedge clk);
      usb_store_req  = 1'b1;
      usb_store_data = 8'h66;
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      usb_store_req = 1'b0;
      checkOutput("clear_ack", usb_ack, 1);
      checkOutput("clear_occ", buffer_occupancy, 0);
      applyStimulus('{1'b0, 1'b1, 8'h42, 6'd0, 1'b0, 7'd1, 8'h00});

      $display("[TB] starvation limit");
      resetDut();
      @(negedge clk);
      usb_store_req  = 1'b1;
      usb_store_data = 8'h55;
      ahb_get_req    = 1'b1;
      n_grants = 0;
      cyc      = 0;
      while (n_grants < 10 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (usb_ack || ahb_ack) begin
            grants[n_grants] = ahb_ack;
            n_grants++;
         end
      end
      dropReqs();
      checkOutput("starve_grant_count", n_grants, 10);
      for (int i = 0; i < n_grants; i++) begin
         checkOutput($sformatf("starve_grant_%0d", i), grants[i], exp_grants[i]);
      end
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
